// File: rtl/capture_sched.sv
// Capture scheduler: pops packet lengths, reserves space in the DDR ring,
// sequences wr_ctrl for each transfer and emits one commit descriptor per packet.
module capture_sched #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] RING_BYTES = 32'h0010_0000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pkt_valid,
  input  logic [15:0] pkt_len,
  output logic        pkt_ready,
  input  logic [31:0] rd_ptr,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] control,
  output logic        commit_valid,
  output logic [31:0] commit_addr,
  output logic [15:0] commit_len,
  output logic [31:0] wr_ptr,
  output logic [31:0] pkt_count,
  output logic        stall,
  output logic        err_timeout
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned RW = LW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic          wrap_q;
  logic [TW-1:0] wait_cnt;

  logic [RW-1:0]   len_r_c;
  logic            wrap_c;
  logic [AW-1:0]   tail_c;
  logic [AW:0]     need_c;
  logic [AW+1:0]   diff_c;
  logic [AW+1:0]   free_c;
  logic [AW-1:0]   begin_c;
  logic [AW-1:0]   next_ptr_c;

  // Ring space arithmetic; free keeps one word of slack so equal pointers mean empty.
  always_comb begin
    len_r_c    = (RW'(len_q) + RW'(3)) & ~RW'(3);
    wrap_c     = (AW'(wr_ptr) + (AW+1)'(len_r_c)) > (AW+1)'(RING_BYTES);
    tail_c     = RING_BYTES - wr_ptr;
    need_c     = wrap_c ? ((AW+1)'(tail_c) + (AW+1)'(len_r_c)) : (AW+1)'(len_r_c);
    diff_c     = (AW+2)'(rd_ptr) - (AW+2)'(wr_ptr) - (AW+2)'(4);
    free_c     = diff_c[AW+1] ? (diff_c + (AW+2)'(RING_BYTES)) : diff_c;
    begin_c    = BASE_ADDR + (wrap_q ? AW'(0) : wr_ptr);
    next_ptr_c = (wrap_q ? AW'(0) : wr_ptr) + AW'(len_r_c);
    if (next_ptr_c == RING_BYTES) next_ptr_c = AW'(0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      wrap_q       <= 1'b0;
      wait_cnt     <= '0;
      pkt_ready    <= 1'b0;
      wr_ctrl      <= 1'b0;
      pkt_begin    <= '0;
      pkt_end      <= '0;
      control      <= '0;
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_len   <= '0;
      wr_ptr       <= '0;
      pkt_count    <= '0;
      stall        <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      pkt_ready    <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            len_q     <= pkt_len;
            pkt_ready <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (len_r_c == '0) begin
            wrap_q <= 1'b0;
            stall  <= 1'b0;
            state  <= COMMIT;
          end else if (free_c >= (AW+2)'(need_c)) begin
            wrap_q <= wrap_c;
            stall  <= 1'b0;
            state  <= ISSUE;
          end else begin
            stall <= 1'b1;
          end
        end
        ISSUE: begin
          pkt_begin <= begin_c;
          pkt_end   <= begin_c + AW'(len_r_c);
          control   <= {wrap_q, 15'b0, len_q};
          wr_ctrl   <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (wr_ctrl_rdy) begin
            wr_ctrl <= 1'b0;
            state   <= COMMIT;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            // Abandon the transfer: no commit, pointer stays where it was.
            wr_ctrl     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        COMMIT: begin
          commit_valid <= 1'b1;
          commit_addr  <= begin_c;
          commit_len   <= len_q;
          pkt_count    <= pkt_count + AW'(1);
          wr_ptr       <= next_ptr_c;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sched.sv
// Directed self-checking bench for capture_sched: single, rounding, wrap,
// stall, zero-length, timeout and mid-transfer reset.
module tb_capture_sched;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] RING = 32'h0002_0000;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic [15:0] pkt_len;
  logic        pkt_ready;
  logic [31:0] rd_ptr;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] control;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [15:0] commit_len;
  logic [31:0] wr_ptr;
  logic [31:0] pkt_count;
  logic        stall;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  capture_sched #(
    .BASE_ADDR (BASE),
    .RING_BYTES(RING),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .pkt_len     (pkt_len),
    .pkt_ready   (pkt_ready),
    .rd_ptr      (rd_ptr),
    .wr_ctrl     (wr_ctrl),
    .wr_ctrl_rdy (wr_ctrl_rdy),
    .pkt_begin   (pkt_begin),
    .pkt_end     (pkt_end),
    .control     (control),
    .commit_valid(commit_valid),
    .commit_addr (commit_addr),
    .commit_len  (commit_len),
    .wr_ptr      (wr_ptr),
    .pkt_count   (pkt_count),
    .stall       (stall),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a length for one cycle; leaves the DUT one edge past CHECK.
  task automatic start_pkt(input logic [15:0] len);
    pkt_valid = 1'b1;
    pkt_len   = len;
    step();
    chk("pkt_ready", 32'(pkt_ready), 32'd1);
    pkt_valid = 1'b0;
    step();
    chk("pkt_ready_pulse", 32'(pkt_ready), 32'd0);
  endtask

  task automatic issue_chk(input logic [31:0] b, input logic [31:0] e, input logic [31:0] c);
    step();
    chk("wr_ctrl_rise", 32'(wr_ctrl), 32'd1);
    chk("pkt_begin", pkt_begin, b);
    chk("pkt_end", pkt_end, e);
    chk("control", control, c);
  endtask

  task automatic hold_chk(input logic [31:0] b, input logic [31:0] e);
    step();
    step();
    chk("wr_ctrl_hold", 32'(wr_ctrl), 32'd1);
    chk("pkt_begin_hold", pkt_begin, b);
    chk("pkt_end_hold", pkt_end, e);
  endtask

  task automatic finish_pkt(input logic [31:0] addr, input logic [15:0] len,
                            input logic [31:0] wp, input logic [31:0] cnt);
    wr_ctrl_rdy = 1'b1;
    step();
    wr_ctrl_rdy = 1'b0;
    chk("wr_ctrl_drop", 32'(wr_ctrl), 32'd0);
    chk("commit_early", 32'(commit_valid), 32'd0);
    step();
    chk("commit_valid", 32'(commit_valid), 32'd1);
    chk("commit_addr", commit_addr, addr);
    chk("commit_len", 32'(commit_len), 32'(len));
    chk("wr_ptr", wr_ptr, wp);
    chk("pkt_count", pkt_count, cnt);
    step();
    chk("commit_pulse", 32'(commit_valid), 32'd0);
  endtask

  task automatic all_zero_chk();
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("rst_pkt_begin", pkt_begin, 32'd0);
    chk("rst_pkt_end", pkt_end, 32'd0);
    chk("rst_control", control, 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_addr", commit_addr, 32'd0);
    chk("rst_commit_len", 32'(commit_len), 32'd0);
    chk("rst_wr_ptr", wr_ptr, 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int  n;
    bit  saw_commit;
    reset       = 1'b1;
    pkt_valid   = 1'b0;
    pkt_len     = '0;
    rd_ptr      = '0;
    wr_ctrl_rdy = 1'b0;
    step();
    step();
    reset = 1'b0;
    all_zero_chk();

    // Stray done pulse while idle must do nothing.
    wr_ctrl_rdy = 1'b1;
    step();
    wr_ctrl_rdy = 1'b0;
    step();
    chk("idle_rdy_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("idle_rdy_commit", 32'(commit_valid), 32'd0);
    chk("idle_rdy_count", pkt_count, 32'd0);

    // Single packet.
    start_pkt(16'd32);
    issue_chk(BASE, BASE + 32'd32, 32'h0000_0020);
    hold_chk(BASE, BASE + 32'd32);
    finish_pkt(BASE, 16'd32, 32'd32, 32'd1);

    // Rounding 61 -> 64.
    start_pkt(16'd61);
    issue_chk(BASE + 32'd32, BASE + 32'd96, 32'h0000_003D);
    finish_pkt(BASE + 32'd32, 16'd61, 32'd96, 32'd2);

    // Large packets to bring wr_ptr to RING-16.
    rd_ptr = 32'd96;
    start_pkt(16'hFFFF);
    issue_chk(BASE + 32'd96, BASE + 32'h0001_0060, 32'h0000_FFFF);
    finish_pkt(BASE + 32'd96, 16'hFFFF, 32'h0001_0060, 32'd3);
    rd_ptr = 32'h0001_0060;
    start_pkt(16'hFF90);
    issue_chk(BASE + 32'h0001_0060, BASE + 32'h0001_FFF0, 32'h0000_FF90);
    finish_pkt(BASE + 32'h0001_0060, 16'hFF90, 32'h0001_FFF0, 32'd4);

    // Wrap: 32 bytes do not fit in the 16-byte tail.
    rd_ptr = 32'd4096;
    start_pkt(16'd32);
    issue_chk(BASE, BASE + 32'd32, 32'h8000_0020);
    finish_pkt(BASE, 16'd32, 32'd32, 32'd5);

    // Stall until the reader frees space.
    rd_ptr = 32'd48;
    start_pkt(16'd64);
    chk("stall_set", 32'(stall), 32'd1);
    chk("stall_no_wr_ctrl", 32'(wr_ctrl), 32'd0);
    step();
    step();
    chk("stall_hold", 32'(stall), 32'd1);
    chk("stall_hold_wr_ctrl", 32'(wr_ctrl), 32'd0);
    rd_ptr = 32'd112;
    step();
    chk("stall_clear", 32'(stall), 32'd0);
    issue_chk(BASE + 32'd32, BASE + 32'd96, 32'h0000_0040);
    finish_pkt(BASE + 32'd32, 16'd64, 32'd96, 32'd6);

    // Zero length: straight to commit.
    start_pkt(16'd0);
    chk("zero_no_wr_ctrl", 32'(wr_ctrl), 32'd0);
    step();
    chk("zero_commit_valid", 32'(commit_valid), 32'd1);
    chk("zero_commit_addr", commit_addr, BASE + 32'd96);
    chk("zero_commit_len", 32'(commit_len), 32'd0);
    chk("zero_wr_ptr", wr_ptr, 32'd96);
    chk("zero_pkt_count", pkt_count, 32'd7);
    chk("zero_wr_ctrl_after", 32'(wr_ctrl), 32'd0);
    step();

    // Timeout: no done pulse.
    rd_ptr = 32'd96;
    start_pkt(16'd8);
    issue_chk(BASE + 32'd96, BASE + 32'd104, 32'h0000_0008);
    n = 0;
    saw_commit = 1'b0;
    while (!err_timeout && n < 100) begin
      step();
      n++;
      if (commit_valid) saw_commit = 1'b1;
    end
    chk("timeout_cycles", 32'(n), 32'(TMO));
    chk("err_timeout", 32'(err_timeout), 32'd1);
    chk("timeout_wr_ctrl", 32'(wr_ctrl), 32'd0);
    step();
    chk("timeout_no_commit", 32'(saw_commit | commit_valid), 32'd0);
    chk("timeout_wr_ptr", wr_ptr, 32'd96);
    chk("timeout_pkt_count", pkt_count, 32'd7);
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // Reset during WAIT.
    start_pkt(16'd8);
    issue_chk(BASE + 32'd96, BASE + 32'd104, 32'h0000_0008);
    reset = 1'b1;
    step();
    reset = 1'b0;
    all_zero_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
